clock_divider_multi: RTL and testbench

//  Parametrised multi-channel power-of-two clock divider with one shared free-running counter.

---
 rtl/clock_divider_multi.sv | 96 +++++++++
 tb/tb_clock_divider_multi.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/clock_divider_multi.sv
// Multi-channel power-of-two clock divider. One shared free-running counter feeds
// per-lane taps whose select changes only at a boundary where both the old and new tap bits are zero.
module clock_divider_lane #(
  parameter int WIDTH = 32,
  parameter int SELW  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [SELW-1:0]  sel,
  input  logic [WIDTH-1:0] cnt_next,
  output logic             clk_div,
  output logic             tick,
  output logic             busy
);
  localparam logic [SELW-1:0] SEL_TOP = SELW'(WIDTH - 1);

  logic [SELW-1:0]  sel_sat, sel_pend, sel_act, sel_max, sel_eff;
  logic [WIDTH-1:0] mask, tap;
  logic             sw;

  always_comb begin
    sel_sat = (sel > SEL_TOP) ? SEL_TOP : sel;
    sel_max = (sel_pend > sel_act) ? sel_pend : sel_act;
    // low (sel_max+1) bits of cnt_next must all be zero before a switch
    mask    = {WIDTH{1'b1}} >> (SEL_TOP - sel_max);
    sw      = en && (sel_pend != sel_act) && ((cnt_next & mask) == '0);
    sel_eff = sw ? sel_pend : sel_act;
    tap     = cnt_next >> sel_eff;
  end

  assign busy = (sel_pend != sel_act);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_pend <= '0;
      sel_act  <= '0;
      clk_div  <= 1'b0;
      tick     <= 1'b0;
    end else begin
      sel_pend <= sel_sat;
      if (clr) begin
        sel_act <= sel_pend;
        clk_div <= 1'b0;
        tick    <= 1'b0;
      end else begin
        sel_act <= sel_eff;
        if (en) begin
          clk_div <= tap[0];
          tick    <= ~clk_div & tap[0];
        end else begin
          tick    <= 1'b0;
        end
      end
    end
  end
endmodule

module clock_divider_multi #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int SELW  = 5
) (
  input  logic                clk,
  input  logic                BTN0,
  input  logic                en,
  input  logic                clr,
  input  logic [NCH*SELW-1:0] sel,
  output logic [WIDTH-1:0]    cnt,
  output logic [NCH-1:0]      clk_div,
  output logic [NCH-1:0]      tick,
  output logic [NCH-1:0]      busy
);
  logic [WIDTH-1:0] cnt_next;

  assign cnt_next = en ? cnt + WIDTH'(1) : cnt;

  always_ff @(posedge clk or negedge BTN0) begin
    if (!BTN0)    cnt <= '0;
    else if (clr) cnt <= '0;
    else          cnt <= cnt_next;
  end

  clock_divider_lane #(.WIDTH(WIDTH), .SELW(SELW)) u_lane [NCH-1:0] (
    .clk      (clk),
    .rst_n    (BTN0),
    .en       (en),
    .clr      (clr),
    .sel      (sel),
    .cnt_next (cnt_next),
    .clk_div  (clk_div),
    .tick     (tick),
    .busy     (busy)
  );
endmodule

// File: tb/tb_clock_divider_multi.sv
// Randomised bench for clock_divider_multi: arithmetic reference model of counter,
// per-channel select hand-over and tap outputs, plus a few hand-computed pins.
module tb_clock_divider_multi;
  localparam int NCH = 2;

  logic            clk = 1'b0;
  logic            BTN0;
  logic            en, clr;
  logic [9:0]      sel;
  logic [31:0]     cnt;
  logic [1:0]      clk_div, tick, busy;
  logic [7:0]      cnt8;
  logic [0:0]      clk_div8, tick8, busy8;

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [31:0] m_cnt;
  int          m_pend [NCH];
  int          m_act  [NCH];
  logic [1:0]  m_div, m_tick;
  int          m8_cnt, m8_pend, m8_act;
  logic        m8_div;

  clock_divider_multi #(.WIDTH(32), .NCH(2), .SELW(5)) dut (
    .clk(clk), .BTN0(BTN0), .en(en), .clr(clr), .sel(sel),
    .cnt(cnt), .clk_div(clk_div), .tick(tick), .busy(busy));

  // narrow instance: select 20 saturates to 7 and the counter wraps every 256 clk
  clock_divider_multi #(.WIDTH(8), .NCH(1), .SELW(5)) dut8 (
    .clk(clk), .BTN0(BTN0), .en(1'b1), .clr(1'b0), .sel(5'd20),
    .cnt(cnt8), .clk_div(clk_div8), .tick(tick8), .busy(busy8));

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_div = 0; m_tick = 0;
    for (int i = 0; i < NCH; i++) begin m_pend[i] = 0; m_act[i] = 0; end
    m8_cnt = 0; m8_pend = 0; m8_act = 0; m8_div = 0;
  endtask

  function automatic bit on_boundary(input longint nxt, input int a, input int b);
    int     m;
    longint period;
    m = (a > b) ? a : b;
    period = 64'd1 << (m + 1);
    return (nxt % period) == 0;
  endfunction

  // advance the model by one rising edge using the inputs held over that edge
  task automatic model_step();
    logic [31:0] nxt;
    int          s;
    logic        bitv;
    nxt = en ? m_cnt + 32'd1 : m_cnt;
    for (int i = 0; i < NCH; i++) begin
      if (clr) begin
        m_act[i] = m_pend[i]; m_div[i] = 0; m_tick[i] = 0;
      end else begin
        if (en && m_pend[i] != m_act[i] && on_boundary(longint'(nxt), m_pend[i], m_act[i]))
          m_act[i] = m_pend[i];
        if (en) begin
          s = m_act[i];
          bitv = nxt[s];
          m_tick[i] = bitv & ~m_div[i];
          m_div[i] = bitv;
        end else m_tick[i] = 0;
      end
      s = int'(sel[i*5 +: 5]);
      m_pend[i] = (s > 31) ? 31 : s;
    end
    m_cnt = clr ? 32'd0 : nxt;
    // narrow instance always enabled, never cleared
    m8_cnt = (m8_cnt + 1) % 256;
    if (m8_pend != m8_act && on_boundary(longint'(m8_cnt), m8_pend, m8_act)) m8_act = m8_pend;
    m8_div = ((m8_cnt >> m8_act) & 1) != 0;
    m8_pend = 7;
  endtask

  function automatic logic [1:0] m_busy();
    logic [1:0] b;
    for (int i = 0; i < NCH; i++) b[i] = (m_pend[i] != m_act[i]);
    return b;
  endfunction

  task automatic compare_all();
    chk("cnt", cnt, m_cnt);
    chk("clk_div", clk_div, m_div);
    chk("tick", tick, m_tick);
    chk("busy", busy, m_busy());
    chk("cnt8", cnt8, m8_cnt);
    chk("clk_div8", clk_div8, m8_div);
    chk("busy8", busy8, (m8_pend != m8_act));
  endtask

  task automatic step();
    @(negedge clk);
    model_step();
    compare_all();
  endtask

  int ticks1;
  logic [31:0] saved;

  initial begin
    BTN0 = 1'b0; en = 1'b1; clr = 1'b0;
    sel = {5'd2, 5'd0};
    model_reset();
    // reset held: everything at zero
    repeat (2) begin
      @(negedge clk);
      chk("rst_cnt", cnt, 0); chk("rst_div", clk_div, 0);
      chk("rst_tick", tick, 0); chk("rst_busy", busy, 0);
    end
    BTN0 = 1'b1;
    step();
    chk("first_cnt", cnt, 1);
    repeat (4) step();
    chk("cnt5", cnt, 5);
    chk("busy1_pending", busy[1], 1);
    // sel0 0->3 at cnt=5: pending until cnt_next=16
    sel = {5'd2, 5'd3};
    repeat (10) step();
    chk("cnt15", cnt, 15);
    chk("busy0_before16", busy[0], 1);
    step();
    chk("busy0_after16", busy[0], 0);
    chk("div0_at16", clk_div[0], 0);
    // channel 1 has period 8 clk: exactly 10 ticks in 80 cycles
    ticks1 = 0;
    repeat (80) begin step(); ticks1 += int'(tick[1]); end
    chk("tick1_count", ticks1, 10);

    sel = {5'd7, 5'd31};
    repeat (600) step();

    // en low: counter and outputs frozen, ticks suppressed
    saved = m_cnt;
    en = 1'b0;
    repeat (5) step();
    chk("en0_cnt_hold", cnt, saved);
    chk("en0_tick", tick, 0);
    en = 1'b1;
    step();
    chk("en1_resume", cnt, saved + 32'd1);

    // clear with a change pending
    sel = {5'd7, 5'd4};
    step();
    chk("busy_before_clr", busy[0], 1);
    clr = 1'b1;
    step();
    chk("clr_cnt", cnt, 0); chk("clr_div", clk_div, 0); chk("clr_busy", busy, 0);
    clr = 1'b0;

    // randomised traffic
    for (int n = 0; n < 400; n++) begin
      en  = ($urandom_range(9) != 0);
      clr = ($urandom_range(39) == 0);
      for (int i = 0; i < NCH; i++)
        if ($urandom_range(15) == 0)
          sel[i*5 +: 5] = ($urandom_range(7) == 0) ? 5'($urandom_range(31)) : 5'($urandom_range(5));
      step();
    end
    en = 1'b1; clr = 1'b0;
    repeat (20) step();

    // asynchronous reset mid-count
    @(negedge clk);
    model_step();
    compare_all();
    #2 BTN0 = 1'b0;
    #1;
    chk("async_cnt", cnt, 0); chk("async_div", clk_div, 0);
    chk("async_tick", tick, 0); chk("async_busy", busy, 0);
    chk("async_cnt8", cnt8, 0);
    model_reset();
    @(negedge clk);
    BTN0 = 1'b1;
    repeat (10) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
